rx_ack_input_stage: RTL and testbench
=====================================

RX_ACK_INPUT_STAGE -- requirements
Module: rx_ack_input_stage

Interface
REQ-001 SHALL have parameter FLOWID_W, default 8, width of flow identifier.
REQ-002 SHALL have ports clk in 1 (sole clock) and rst in 1 (synchronous, active-high).
REQ-003 SHALL have hdr_val in 1, hdr_rdy out 1, hdr_flowid in FLOWID_W, hdr_seq_num in `SEQ_NUM_W, hdr_payload_len in PAYLOAD_ENTRY_LEN_W: incoming parsed packet.
REQ-004 SHALL have state_rd_req_val out 1, state_rd_req_flowid out FLOWID_W: flow-state read request; the memory is always ready.
REQ-005 SHALL have state_rd_resp_val in 1, state_rd_resp_ack_num in `ACK_NUM_W, state_rd_resp_head_idx and state_rd_resp_tail_idx in RX_PAYLOAD_IDX_W+1: flow-state read data.
REQ-006 SHALL have malloc_req_val out 1, malloc_req_rdy in 1, malloc_req_len out PAYLOAD_ENTRY_LEN_W: RX buffer allocation request.
REQ-007 SHALL have malloc_resp_val in 1, malloc_resp_success in 1, malloc_resp_approx_space in RX_PAYLOAD_PTR_W+1: allocation result.
REQ-008 SHALL have wb_val in 1, wb_flowid in FLOWID_W, wb_ack_num in `ACK_NUM_W, wb_tail_idx in RX_PAYLOAD_IDX_W+1: state write-back from the downstream ACK stage.
REQ-009 SHALL have out_val out 1, out_rdy in 1, and the out_flowid, out_seq_num, out_payload_len, out_curr_ack_num, out_head_idx, out_tail_idx, out_malloc_success and out_approx_space outputs, with widths matching REQ-003/005/007.

Function
REQ-010 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, DECIDE, MALLOC_REQ, MALLOC_WAIT and OUT; one packet in flight at a time.
REQ-011 SHALL assert hdr_rdy only in IDLE, capture the header on hdr_val&hdr_rdy, and go to RD_REQ.
REQ-012 SHALL pulse state_rd_req_val for exactly one cycle in RD_REQ, then stay in RD_WAIT until state_rd_resp_val, capture the response, and go to DECIDE.
REQ-013 SHALL, in DECIDE, request malloc only if seq_num==curr_ack, payload_len!=0, and (tail-head) < 2^RX_PAYLOAD_IDX_W, all modulo 2^(RX_PAYLOAD_IDX_W+1); otherwise go directly to OUT with out_malloc_success=0.
REQ-014 SHALL hold malloc_req_val high in MALLOC_REQ until malloc_req_rdy, then wait in MALLOC_WAIT for malloc_resp_val, capture success and approx_space, and go to OUT.
REQ-015 SHALL keep a last_space register updated by every malloc response; when malloc is skipped, out_approx_space=last_space.
REQ-016 SHALL, from header capture until the output handshake, overwrite the captured ack_num and tail_idx with wb values whenever wb_val and wb_flowid match; when wb coincides with state_rd_resp_val, wb wins.
REQ-017 SHALL hold out_val and all out_* stable in OUT until out_rdy, then return to IDLE; minimum throughput is one packet per 5 cycles.
REQ-018 SHALL keep out_val, state_rd_req_val and malloc_req_val low in every state other than OUT, RD_REQ and MALLOC_REQ respectively.

Reset
REQ-019 SHALL, on rst, enter IDLE, drive all *_val outputs to 0 and all out_* data outputs to 0, and set last_space to 2^RX_PAYLOAD_PTR_W.
REQ-020 SHALL discard the in-flight packet on reset mid-operation and ignore any response arriving in the cycle rst is asserted; the allocator shares rst.

Configuration
REQ-021 SHALL, when RX_ACK_INPUT_STATS_EN is defined, provide 32-bit saturating outputs stat_pkts, stat_malloc_skip and stat_malloc_fail, reset to 0 and incremented respectively on the output handshake, on a DECIDE skip, and on a failed malloc response.
REQ-022 SHALL, when RX_ACK_INPUT_STATS_EN is undefined, omit those ports and counters, with otherwise identical behaviour.

Structure
REQ-023 SHALL define a rx_ack_in_struct output-bundle typedef and the FSM state enum in tcp_pkg.
REQ-024 SHALL place the DECIDE predicate (REQ-013) in a combinational sub-module named rx_ack_precheck.

Verification
REQ-025 In-order packet: state ack=1000, head=tail=0, seq=1000, len=64, malloc success with space=4000 -> out_malloc_success=1, out_approx_space=4000, out_curr_ack_num=1000.
REQ-026 Out-of-order packet: ack=1000, seq=1064 -> no malloc_req_val; out_malloc_success=0; out_approx_space=last_space.
REQ-027 Index full: head=0, tail=2^RX_PAYLOAD_IDX_W -> malloc skipped, out_malloc_success=0; also check wrap with head=2^RX_PAYLOAD_IDX_W-1, tail=1.
REQ-028 Forwarding: wb(flow 3, ack=2064, tail=5) on the same cycle as the read response (ack=2000) for flow 3 -> out_curr_ack_num=2064, out_tail_idx=5.
REQ-029 Backpressure: hold out_rdy low for 10 cycles -> out_* stable and hdr_rdy=0 throughout; with malloc_req_rdy low for 7 cycles -> malloc_req_val stays high.
REQ-030 Reset during MALLOC_WAIT -> next cycle IDLE, all *_val=0, last_space=2^RX_PAYLOAD_PTR_W, and the next packet processes normally.

Source files
------------

// File: rtl/tcp_pkg.sv
// Shared widths, FSM state encoding and output bundle for the RX ACK input stage.
// Sequence/ACK widths are global macros so other TCP blocks can share them.
`ifndef SEQ_NUM_W
`define SEQ_NUM_W 32
`endif
`ifndef ACK_NUM_W
`define ACK_NUM_W 32
`endif

package tcp_pkg;
    localparam int PAYLOAD_ENTRY_LEN_W = 16;
    localparam int RX_PAYLOAD_IDX_W    = 4;
    localparam int RX_PAYLOAD_PTR_W    = 14;

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, DECIDE, MALLOC_REQ, MALLOC_WAIT, OUT
    } rx_ack_in_state_e;

    // Flow id is kept outside the bundle because its width is a module parameter
    typedef struct packed {
        logic [`SEQ_NUM_W-1:0]          seq_num;
        logic [PAYLOAD_ENTRY_LEN_W-1:0] payload_len;
        logic [`ACK_NUM_W-1:0]          curr_ack_num;
        logic [RX_PAYLOAD_IDX_W:0]      head_idx;
        logic [RX_PAYLOAD_IDX_W:0]      tail_idx;
        logic                           malloc_success;
        logic [RX_PAYLOAD_PTR_W:0]      approx_space;
    } rx_ack_in_struct;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/rx_ack_precheck.sv
// Decides whether a packet may allocate RX buffer space: it must be in order,
// non-empty, and the payload index ring must not be full (modular distance).
module rx_ack_precheck
    import tcp_pkg::*;
(
    input  logic [`SEQ_NUM_W-1:0]          i_seq_num,
    input  logic [`ACK_NUM_W-1:0]          i_ack_num,
    input  logic [PAYLOAD_ENTRY_LEN_W-1:0] i_payload_len,
    input  logic [RX_PAYLOAD_IDX_W:0]      i_head_idx,
    input  logic [RX_PAYLOAD_IDX_W:0]      i_tail_idx,
    output logic                           o_malloc_ok
);
    logic [RX_PAYLOAD_IDX_W:0] w_used;

    // Indices carry one extra wrap bit, so occupancy is just the modular difference
    assign w_used      = i_tail_idx - i_head_idx;
    assign o_malloc_ok = (i_seq_num == i_ack_num) && (i_payload_len != '0) &&
                         !w_used[RX_PAYLOAD_IDX_W];
endmodule

// File: rtl/rx_ack_input_stage.sv
// RX ACK input stage: per-packet flow-state lookup, buffer allocation and hand-off.
// Optional statistics counters are enabled with `define RX_ACK_INPUT_STATS_EN.
module rx_ack_input_stage
    import tcp_pkg::*;
#(
    parameter int FLOWID_W = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           hdr_val,
    output logic                           hdr_rdy,
    input  logic [FLOWID_W-1:0]            hdr_flowid,
    input  logic [`SEQ_NUM_W-1:0]          hdr_seq_num,
    input  logic [PAYLOAD_ENTRY_LEN_W-1:0] hdr_payload_len,
    output logic                           state_rd_req_val,
    output logic [FLOWID_W-1:0]            state_rd_req_flowid,
    input  logic                           state_rd_resp_val,
    input  logic [`ACK_NUM_W-1:0]          state_rd_resp_ack_num,
    input  logic [RX_PAYLOAD_IDX_W:0]      state_rd_resp_head_idx,
    input  logic [RX_PAYLOAD_IDX_W:0]      state_rd_resp_tail_idx,
    output logic                           malloc_req_val,
    input  logic                           malloc_req_rdy,
    output logic [PAYLOAD_ENTRY_LEN_W-1:0] malloc_req_len,
    input  logic                           malloc_resp_val,
    input  logic                           malloc_resp_success,
    input  logic [RX_PAYLOAD_PTR_W:0]      malloc_resp_approx_space,
    input  logic                           wb_val,
    input  logic [FLOWID_W-1:0]            wb_flowid,
    input  logic [`ACK_NUM_W-1:0]          wb_ack_num,
    input  logic [RX_PAYLOAD_IDX_W:0]      wb_tail_idx,
    output logic                           out_val,
    input  logic                           out_rdy,
    output logic [FLOWID_W-1:0]            out_flowid,
    output logic [`SEQ_NUM_W-1:0]          out_seq_num,
    output logic [PAYLOAD_ENTRY_LEN_W-1:0] out_payload_len,
    output logic [`ACK_NUM_W-1:0]          out_curr_ack_num,
    output logic [RX_PAYLOAD_IDX_W:0]      out_head_idx,
    output logic [RX_PAYLOAD_IDX_W:0]      out_tail_idx,
    output logic                           out_malloc_success,
    output logic [RX_PAYLOAD_PTR_W:0]      out_approx_space
`ifdef RX_ACK_INPUT_STATS_EN
    ,
    output logic [31:0]                    stat_pkts,
    output logic [31:0]                    stat_malloc_skip,
    output logic [31:0]                    stat_malloc_fail
`endif
);
    localparam logic [RX_PAYLOAD_PTR_W:0] SPACE_RESET = {1'b1, {RX_PAYLOAD_PTR_W{1'b0}}};

    rx_ack_in_state_e          r_state, w_state_nxt;
    rx_ack_in_struct           r_pkt;
    logic [FLOWID_W-1:0]       r_flowid;
    logic [RX_PAYLOAD_PTR_W:0] r_last_space;
    logic                      w_malloc_ok;
    logic                      w_wb_hit;

    rx_ack_precheck u_precheck (
        .i_seq_num     (r_pkt.seq_num),
        .i_ack_num     (r_pkt.curr_ack_num),
        .i_payload_len (r_pkt.payload_len),
        .i_head_idx    (r_pkt.head_idx),
        .i_tail_idx    (r_pkt.tail_idx),
        .o_malloc_ok   (w_malloc_ok)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt      = r_state;
        hdr_rdy          = 1'b0;
        state_rd_req_val = 1'b0;
        malloc_req_val   = 1'b0;
        out_val          = 1'b0;
        case (r_state)
            IDLE: begin
                hdr_rdy = 1'b1;
                if (hdr_val) w_state_nxt = RD_REQ;
            end
            RD_REQ: begin
                state_rd_req_val = 1'b1;
                w_state_nxt      = RD_WAIT;
            end
            RD_WAIT:     if (state_rd_resp_val) w_state_nxt = DECIDE;
            DECIDE:      w_state_nxt = w_malloc_ok ? MALLOC_REQ : OUT;
            MALLOC_REQ: begin
                malloc_req_val = 1'b1;
                if (malloc_req_rdy) w_state_nxt = MALLOC_WAIT;
            end
            MALLOC_WAIT: if (malloc_resp_val) w_state_nxt = OUT;
            OUT: begin
                out_val = 1'b1;
                if (out_rdy) w_state_nxt = IDLE;
            end
            default:     w_state_nxt = IDLE;
        endcase
    end

    // Write-back forwarding is live for the whole time a packet is held
    assign w_wb_hit = (r_state != IDLE) && wb_val && (wb_flowid == r_flowid);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flowid     <= '0;
            r_pkt        <= '0;
            r_last_space <= SPACE_RESET;
        end else begin
            if (r_state == IDLE && hdr_val) begin
                r_flowid             <= hdr_flowid;
                r_pkt.seq_num        <= hdr_seq_num;
                r_pkt.payload_len    <= hdr_payload_len;
                r_pkt.malloc_success <= 1'b0;
            end
            if (r_state == RD_WAIT && state_rd_resp_val) begin
                r_pkt.curr_ack_num <= state_rd_resp_ack_num;
                r_pkt.head_idx     <= state_rd_resp_head_idx;
                r_pkt.tail_idx     <= state_rd_resp_tail_idx;
            end
            // Later assignment gives the write-back priority over the read response
            if (w_wb_hit) begin
                r_pkt.curr_ack_num <= wb_ack_num;
                r_pkt.tail_idx     <= wb_tail_idx;
            end
            if (r_state == DECIDE && !w_malloc_ok) begin
                r_pkt.malloc_success <= 1'b0;
                r_pkt.approx_space   <= r_last_space;
            end
            if (r_state == MALLOC_WAIT && malloc_resp_val) begin
                r_pkt.malloc_success <= malloc_resp_success;
                r_pkt.approx_space   <= malloc_resp_approx_space;
            end
            if (malloc_resp_val) r_last_space <= malloc_resp_approx_space;
        end
    end

    assign state_rd_req_flowid = r_flowid;
    assign malloc_req_len      = r_pkt.payload_len;
    assign out_flowid          = r_flowid;
    assign out_seq_num         = r_pkt.seq_num;
    assign out_payload_len     = r_pkt.payload_len;
    assign out_curr_ack_num    = r_pkt.curr_ack_num;
    assign out_head_idx        = r_pkt.head_idx;
    assign out_tail_idx        = r_pkt.tail_idx;
    assign out_malloc_success  = r_pkt.malloc_success;
    assign out_approx_space    = r_pkt.approx_space;

`ifdef RX_ACK_INPUT_STATS_EN
    logic [31:0] r_stat_pkts, r_stat_skip, r_stat_fail;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_pkts <= '0;
            r_stat_skip <= '0;
            r_stat_fail <= '0;
        end else begin
            if (r_state == OUT && out_rdy)          r_stat_pkts <= sat_inc32(r_stat_pkts);
            if (r_state == DECIDE && !w_malloc_ok)  r_stat_skip <= sat_inc32(r_stat_skip);
            if (r_state == MALLOC_WAIT && malloc_resp_val && !malloc_resp_success)
                r_stat_fail <= sat_inc32(r_stat_fail);
        end
    end

    assign stat_pkts        = r_stat_pkts;
    assign stat_malloc_skip = r_stat_skip;
    assign stat_malloc_fail = r_stat_fail;
`endif
endmodule

// File: tb/tb_rx_ack_input_stage.sv
// Randomized bench for rx_ack_input_stage with a per-packet expectation model.
module tb_rx_ack_input_stage;
    localparam int FW   = 8;
    localparam int LW   = tcp_pkg::PAYLOAD_ENTRY_LEN_W;
    localparam int IW   = tcp_pkg::RX_PAYLOAD_IDX_W;
    localparam int PW   = tcp_pkg::RX_PAYLOAD_PTR_W;
    localparam int RING = 2 ** (IW + 1);
    localparam int SW   = `SEQ_NUM_W;
    localparam int AW   = `ACK_NUM_W;

    logic clk = 1'b0;
    logic rst;
    logic hdr_val, hdr_rdy;
    logic [FW-1:0] hdr_flowid;
    logic [SW-1:0] hdr_seq_num;
    logic [LW-1:0] hdr_payload_len;
    logic state_rd_req_val;
    logic [FW-1:0] state_rd_req_flowid;
    logic state_rd_resp_val;
    logic [AW-1:0] state_rd_resp_ack_num;
    logic [IW:0] state_rd_resp_head_idx, state_rd_resp_tail_idx;
    logic malloc_req_val, malloc_req_rdy;
    logic [LW-1:0] malloc_req_len;
    logic malloc_resp_val, malloc_resp_success;
    logic [PW:0] malloc_resp_approx_space;
    logic wb_val;
    logic [FW-1:0] wb_flowid;
    logic [AW-1:0] wb_ack_num;
    logic [IW:0] wb_tail_idx;
    logic out_val, out_rdy;
    logic [FW-1:0] out_flowid;
    logic [SW-1:0] out_seq_num;
    logic [LW-1:0] out_payload_len;
    logic [AW-1:0] out_curr_ack_num;
    logic [IW:0] out_head_idx, out_tail_idx;
    logic out_malloc_success;
    logic [PW:0] out_approx_space;
`ifdef RX_ACK_INPUT_STATS_EN
    logic [31:0] stat_pkts, stat_malloc_skip, stat_malloc_fail;
`endif

    rx_ack_input_stage #(.FLOWID_W(FW)) dut (
`ifdef RX_ACK_INPUT_STATS_EN
        .stat_pkts(stat_pkts), .stat_malloc_skip(stat_malloc_skip),
        .stat_malloc_fail(stat_malloc_fail),
`endif
        .clk(clk), .rst(rst),
        .hdr_val(hdr_val), .hdr_rdy(hdr_rdy), .hdr_flowid(hdr_flowid),
        .hdr_seq_num(hdr_seq_num), .hdr_payload_len(hdr_payload_len),
        .state_rd_req_val(state_rd_req_val), .state_rd_req_flowid(state_rd_req_flowid),
        .state_rd_resp_val(state_rd_resp_val), .state_rd_resp_ack_num(state_rd_resp_ack_num),
        .state_rd_resp_head_idx(state_rd_resp_head_idx),
        .state_rd_resp_tail_idx(state_rd_resp_tail_idx),
        .malloc_req_val(malloc_req_val), .malloc_req_rdy(malloc_req_rdy),
        .malloc_req_len(malloc_req_len),
        .malloc_resp_val(malloc_resp_val), .malloc_resp_success(malloc_resp_success),
        .malloc_resp_approx_space(malloc_resp_approx_space),
        .wb_val(wb_val), .wb_flowid(wb_flowid), .wb_ack_num(wb_ack_num),
        .wb_tail_idx(wb_tail_idx),
        .out_val(out_val), .out_rdy(out_rdy), .out_flowid(out_flowid),
        .out_seq_num(out_seq_num), .out_payload_len(out_payload_len),
        .out_curr_ack_num(out_curr_ack_num), .out_head_idx(out_head_idx),
        .out_tail_idx(out_tail_idx), .out_malloc_success(out_malloc_success),
        .out_approx_space(out_approx_space)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    logic [PW:0] m_last_space;
    int m_pkts, m_skip, m_fail;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_after_reset(input string tag);
        chk({tag, ":hdr_rdy"}, 64'(hdr_rdy), 64'd1);
        chk({tag, ":vals"}, 64'({out_val, state_rd_req_val, malloc_req_val}), 64'd0);
        chk({tag, ":out_data"}, 64'({out_flowid, out_seq_num, out_payload_len}), 64'd0);
        chk({tag, ":out_state"}, 64'({out_curr_ack_num, out_head_idx, out_tail_idx,
                                      out_malloc_success, out_approx_space}), 64'd0);
    endtask

    // wbm: 0 no write-back, 1 matching write-back with the read response,
    //      2 non-matching write-back with the read response
    task automatic run_pkt(input string tag, input logic [FW-1:0] fl, input logic [SW-1:0] seq,
                           input logic [LW-1:0] len, input logic [AW-1:0] ack,
                           input logic [IW:0] head, input logic [IW:0] tail, input int wbm,
                           input logic [AW-1:0] wack, input logic [IW:0] wtail,
                           input bit msucc, input logic [PW:0] mspace, input int rdd,
                           input int mrd, input int mwd, input int od, input bit abort);
        logic [AW-1:0] ack_e;
        logic [IW:0]   tail_e;
        int            used;
        bit            allow, held;
        logic          exp_s;
        logic [PW:0]   exp_sp;
        logic [127:0]  snap;

        ack_e  = (wbm == 1) ? wack : ack;
        tail_e = (wbm == 1) ? wtail : tail;
        used   = (int'(tail_e) - int'(head) + RING) % RING;
        allow  = (seq == ack_e) && (len != 0) && (used < RING / 2);

        chk({tag, ":hdr_rdy_idle"}, 64'(hdr_rdy), 64'd1);
        hdr_val = 1'b1; hdr_flowid = fl; hdr_seq_num = seq; hdr_payload_len = len;
        step();
        hdr_val = 1'b0;
        chk({tag, ":rd_req"}, 64'(state_rd_req_val), 64'd1);
        chk({tag, ":rd_flow"}, 64'(state_rd_req_flowid), 64'(fl));
        step();
        chk({tag, ":rd_pulse"}, 64'({state_rd_req_val, hdr_rdy}), 64'd0);
        repeat (rdd) step();
        state_rd_resp_val = 1'b1; state_rd_resp_ack_num = ack;
        state_rd_resp_head_idx = head; state_rd_resp_tail_idx = tail;
        if (wbm != 0) begin
            wb_val = 1'b1; wb_flowid = (wbm == 1) ? fl : fl ^ 8'h01;
            wb_ack_num = wack; wb_tail_idx = wtail;
        end
        step();
        state_rd_resp_val = 1'b0; wb_val = 1'b0;
        chk({tag, ":decide_quiet"}, 64'({malloc_req_val, out_val}), 64'd0);
        step();
        if (allow) begin
            chk({tag, ":mreq"}, 64'(malloc_req_val), 64'd1);
            chk({tag, ":mlen"}, 64'(malloc_req_len), 64'(len));
            held = 1'b1;
            repeat (mrd) begin
                step();
                if (malloc_req_val !== 1'b1) held = 1'b0;
            end
            chk({tag, ":mreq_hold"}, 64'(held), 64'd1);
            malloc_req_rdy = 1'b1;
            step();
            malloc_req_rdy = 1'b0;
            chk({tag, ":mreq_drop"}, 64'({malloc_req_val, out_val}), 64'd0);
            repeat (mwd) step();
            malloc_resp_val = 1'b1;
            if (abort) begin
                rst = 1'b1; malloc_resp_success = 1'b1; malloc_resp_approx_space = 15'd123;
                step();
                rst = 1'b0; malloc_resp_val = 1'b0;
                m_last_space = 15'(1) << PW;
                m_pkts = 0; m_skip = 0; m_fail = 0;
                check_idle_after_reset({tag, ":abort"});
                return;
            end
            malloc_resp_success = msucc; malloc_resp_approx_space = mspace;
            step();
            malloc_resp_val = 1'b0;
            m_last_space = mspace;
            exp_s = msucc; exp_sp = mspace;
            if (!msucc) m_fail++;
        end else begin
            chk({tag, ":mreq_skip"}, 64'(malloc_req_val), 64'd0);
            exp_s = 1'b0; exp_sp = m_last_space;
            m_skip++;
        end
        chk({tag, ":out_val"}, 64'(out_val), 64'd1);
        chk({tag, ":out_hdr"}, 64'({out_flowid, out_seq_num, out_payload_len}),
            64'({fl, seq, len}));
        chk({tag, ":out_ack"}, 64'(out_curr_ack_num), 64'(ack_e));
        chk({tag, ":out_idx"}, 64'({out_head_idx, out_tail_idx}), 64'({head, tail_e}));
        chk({tag, ":out_malloc"}, 64'({out_malloc_success, out_approx_space}),
            64'({exp_s, exp_sp}));
        snap = {out_flowid, out_seq_num, out_payload_len, out_curr_ack_num, out_head_idx,
                out_tail_idx, out_malloc_success, out_approx_space};
        held = 1'b1;
        repeat (od) begin
            step();
            if (out_val !== 1'b1 || hdr_rdy !== 1'b0 ||
                snap !== {out_flowid, out_seq_num, out_payload_len, out_curr_ack_num,
                          out_head_idx, out_tail_idx, out_malloc_success, out_approx_space})
                held = 1'b0;
        end
        if (od > 0) chk({tag, ":out_stable"}, 64'(held), 64'd1);
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;
        m_pkts++;
        chk({tag, ":done"}, 64'({out_val, hdr_rdy}), 64'b01);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [FW-1:0] fl;
        logic [AW-1:0] ack, wack, ack_e;
        logic [SW-1:0] seq;
        logic [LW-1:0] len;
        logic [IW:0]   head, tail, wtail;
        int            wbm;

        rst = 1'b1; hdr_val = 0; hdr_flowid = 0; hdr_seq_num = 0; hdr_payload_len = 0;
        state_rd_resp_val = 0; state_rd_resp_ack_num = 0;
        state_rd_resp_head_idx = 0; state_rd_resp_tail_idx = 0;
        malloc_req_rdy = 0; malloc_resp_val = 0; malloc_resp_success = 0;
        malloc_resp_approx_space = 0; wb_val = 0; wb_flowid = 0; wb_ack_num = 0;
        wb_tail_idx = 0; out_rdy = 0;
        m_last_space = 15'(1) << PW; m_pkts = 0; m_skip = 0; m_fail = 0;
        repeat (3) step();
        rst = 1'b0;
        check_idle_after_reset("reset");

        run_pkt("zero_len", 8'd9, 32'd50, 16'd0, 32'd50, 5'd0, 5'd0, 0, 0, 0, 1, 15'd0, 0, 0, 0, 0, 0);
        run_pkt("in_order", 8'd1, 32'd1000, 16'd64, 32'd1000, 5'd0, 5'd0, 0, 0, 0, 1, 15'd4000, 1, 0, 1, 0, 0);
        run_pkt("ooo", 8'd1, 32'd1064, 16'd64, 32'd1000, 5'd0, 5'd0, 0, 0, 0, 1, 15'd77, 0, 0, 0, 0, 0);
        run_pkt("idx_full", 8'd2, 32'd7, 16'd8, 32'd7, 5'd0, 5'd16, 0, 0, 0, 1, 15'd77, 0, 0, 0, 0, 0);
        run_pkt("idx_wrap", 8'd2, 32'd7, 16'd8, 32'd7, 5'd15, 5'd1, 0, 0, 0, 1, 15'd77, 2, 0, 0, 0, 0);
        run_pkt("idx_wrap_ok", 8'd2, 32'd7, 16'd8, 32'd7, 5'd30, 5'd3, 0, 0, 0, 0, 15'd321, 0, 0, 2, 0, 0);
        run_pkt("fwd", 8'd3, 32'd2064, 16'd10, 32'd2000, 5'd0, 5'd0, 1, 32'd2064, 5'd5, 1, 15'd900, 0, 0, 0, 0, 0);
        run_pkt("backpres", 8'd4, 32'd11, 16'd20, 32'd11, 5'd2, 5'd4, 0, 0, 0, 1, 15'd555, 0, 7, 1, 10, 0);
        run_pkt("abort", 8'd5, 32'd12, 16'd20, 32'd12, 5'd2, 5'd4, 0, 0, 0, 1, 15'd555, 0, 1, 1, 0, 1);
        run_pkt("post_rst_skip", 8'd6, 32'd99, 16'd20, 32'd12, 5'd2, 5'd4, 0, 0, 0, 1, 15'd0, 0, 0, 0, 0, 0);
        run_pkt("post_rst_ok", 8'd6, 32'd12, 16'd20, 32'd12, 5'd2, 5'd4, 0, 0, 0, 1, 15'd2345, 0, 0, 0, 1, 0);

        for (int i = 0; i < 40; i++) begin
            fl    = 8'($urandom);
            ack   = $urandom;
            wbm   = $urandom_range(0, 2);
            wack  = $urandom;
            wtail = 5'($urandom);
            head  = 5'($urandom);
            tail  = head + 5'($urandom_range(0, 20));
            ack_e = (wbm == 1) ? wack : ack;
            seq   = ($urandom_range(0, 3) != 0) ? ack_e : ack_e + 32'($urandom_range(1, 500));
            len   = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
            run_pkt($sformatf("rnd%0d", i), fl, seq, len, ack, head, tail, wbm, wack, wtail,
                    1'($urandom), 15'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), 0);
        end

`ifdef RX_ACK_INPUT_STATS_EN
        chk("stat_pkts", 64'(stat_pkts), 64'(m_pkts));
        chk("stat_skip", 64'(stat_malloc_skip), 64'(m_skip));
        chk("stat_fail", 64'(stat_malloc_fail), 64'(m_fail));
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
